// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b opcode and memory-stage state types
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'd0,
        op_add  = 4'd1,
        op_ldb  = 4'd2,
        op_stb  = 4'd3,
        op_jsr  = 4'd4,
        op_and  = 4'd5,
        op_ldr  = 4'd6,
        op_str  = 4'd7,
        op_rti  = 4'd8,
        op_not  = 4'd9,
        op_ldi  = 4'd10,
        op_sti  = 4'd11,
        op_jmp  = 4'd12,
        op_shf  = 4'd13,
        op_lea  = 4'd14,
        op_trap = 4'd15
    } lc3b_opcode;

    typedef enum logic {
        IDLE = 1'b0,
        IND  = 1'b1
    } mem_state_t;

    function automatic logic is_mem_op(lc3b_opcode op);
        return (op == op_ldr) || (op == op_ldb) || (op == op_ldi) ||
               (op == op_str) || (op == op_stb) || (op == op_sti) ||
               (op == op_trap);
    endfunction

endpackage

// File: rtl/mem_byte_fmt.sv
// rtl/mem_byte_fmt.sv - byte-lane steering for stores and sign-extension for byte loads
module mem_byte_fmt
    import lc3b_types::*;
(
    input  lc3b_opcode  opcode,
    input  logic        addr_lsb,
    input  logic [15:0] st_data,
    input  logic [15:0] mem_rdata,
    output logic [15:0] wdata,
    output logic [1:0]  byte_enable,
    output logic [15:0] load_data
);

    logic [7:0] rd_byte;

    always_comb begin
        wdata       = st_data;
        byte_enable = 2'b11;
        load_data   = mem_rdata;
        rd_byte     = addr_lsb ? mem_rdata[15:8] : mem_rdata[7:0];
        if (opcode == op_stb) begin
            // Byte replicated on both lanes; the enable picks the lane that lands.
            wdata       = {st_data[7:0], st_data[7:0]};
            byte_enable = addr_lsb ? 2'b10 : 2'b01;
        end
        if (opcode == op_ldb) begin
            load_data = {{8{rd_byte[7]}}, rd_byte};
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - LC-3b MEM stage: d-cache sequencing, indirect ops, stall counting
module mem_stage_ctrl
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  lc3b_opcode           opcode,
    input  logic [15:0]          addr_in,
    input  logic [15:0]          st_data,
    input  logic                 mem_resp,
    input  logic [15:0]          mem_rdata,
    output logic [15:0]          mem_addr,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [1:0]           mem_byte_enable,
    output logic [15:0]          mem_wdata,
    output logic [15:0]          load_data,
    output logic                 done,
    output logic                 stall,
    output logic [CNT_WIDTH-1:0] stall_count
);

    mem_state_t           state_q, state_d;
    logic [14:0]          ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic [15:0] fmt_wdata;
    logic [1:0]  fmt_be;
    logic [15:0] fmt_load;
    logic        is_ind;
    logic        is_byte;
    logic        is_st;

    mem_byte_fmt u_fmt (
        .opcode      (opcode),
        .addr_lsb    (addr_in[0]),
        .st_data     (st_data),
        .mem_rdata   (mem_rdata),
        .wdata       (fmt_wdata),
        .byte_enable (fmt_be),
        .load_data   (fmt_load)
    );

    assign is_ind  = (opcode == op_ldi) || (opcode == op_sti);
    assign is_byte = (opcode == op_ldb) || (opcode == op_stb);
    assign is_st   = (opcode == op_str) || (opcode == op_stb);

    // Requests are combinational so zero-wait responses complete with no stall.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        mem_addr        = 16'h0000;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        mem_wdata       = 16'h0000;
        load_data       = 16'h0000;
        done            = 1'b0;
        stall           = 1'b0;
        if (rst_n && valid) begin
            if (!is_mem_op(opcode)) begin
                done    = 1'b1;
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                mem_addr        = is_byte ? addr_in : {addr_in[15:1], 1'b0};
                mem_write       = is_st;
                mem_read        = !is_st;
                mem_byte_enable = is_st ? fmt_be : 2'b11;
                mem_wdata       = is_st ? fmt_wdata : 16'h0000;
                if (mem_resp) begin
                    if (is_ind) begin
                        // Pointer fetched; the real access follows from IND.
                        ptr_d   = mem_rdata[15:1];
                        state_d = IND;
                        stall   = 1'b1;
                    end else begin
                        done      = 1'b1;
                        load_data = is_st ? 16'h0000 : fmt_load;
                    end
                end else begin
                    stall = 1'b1;
                end
            end else if (is_ind) begin
                mem_addr        = {ptr_q, 1'b0};
                mem_byte_enable = 2'b11;
                mem_read        = (opcode == op_ldi);
                mem_write       = (opcode == op_sti);
                mem_wdata       = (opcode == op_sti) ? st_data : 16'h0000;
                if (mem_resp) begin
                    done      = 1'b1;
                    state_d   = IDLE;
                    load_data = (opcode == op_ldi) ? mem_rdata : 16'h0000;
                end else begin
                    stall = 1'b1;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (stall && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign stall_count = cnt_q;

endmodule
